mem_io_responder: RTL

- Responder on the byte-wide memory bus driven by the CPU-side memory controller: byte-addressed RAM plus a memory-mapped IO window.
- Returns read data exactly one cycle after the address is presented and commits writes on the presenting edge.
- The IO window (cpu_a[17:16]==2'b11) fronts a UART-style transmit FIFO and receive FIFO, a status register and a program-done strobe.
- Sits at the top level between the memory controller and the RAM/host-interface pins.

---
 rtl/mem_io_responder_if.sv | 25 ++
 rtl/mem_io_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the CPU-side controller and mem_io_responder.
// Carries the CPU bus, the transmit drain, the receive feed and the IO strobes.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        io_buffer_full;
    logic        program_done;

    modport master (
        output cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        input  cpu_din, tx_data, tx_valid, io_buffer_full, program_done
    );

    modport slave (
        input  cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        output cpu_din, tx_data, tx_valid, io_buffer_full, program_done
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus IO window (tx/rx FIFOs, status, program-done) on the CPU memory bus.
// RAM contents are undefined until written.
module mem_io_responder #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TX_DEPTH_LOG = 3,
    parameter int unsigned RX_DEPTH_LOG = 3,
    parameter string       INIT_FILE    = "test.data"
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    mem_io_responder_if.slave   bus
);
    localparam int unsigned RAM_SIZE = 2 ** ADDR_WIDTH;
    localparam int unsigned TX_DEPTH = 2 ** TX_DEPTH_LOG;
    localparam int unsigned RX_DEPTH = 2 ** RX_DEPTH_LOG;

    localparam logic [TX_DEPTH_LOG:0]   TX_CNT_FULL = {1'b1, {TX_DEPTH_LOG{1'b0}}};
    localparam logic [TX_DEPTH_LOG:0]   TX_CNT_HIGH = {1'b0, {TX_DEPTH_LOG{1'b1}}};
    localparam logic [TX_DEPTH_LOG:0]   TX_CNT_ONE  = (TX_DEPTH_LOG + 1)'(1);
    localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE  = TX_DEPTH_LOG'(1);
    localparam logic [RX_DEPTH_LOG:0]   RX_CNT_FULL = {1'b1, {RX_DEPTH_LOG{1'b0}}};
    localparam logic [RX_DEPTH_LOG:0]   RX_CNT_ONE  = (RX_DEPTH_LOG + 1)'(1);
    localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE  = RX_DEPTH_LOG'(1);

    logic [7:0] r_ram [RAM_SIZE];

    logic [7:0]              r_tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] r_tx_wp, r_tx_rp;
    logic [TX_DEPTH_LOG:0]   r_tx_cnt;
    logic [7:0]              r_rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG-1:0] r_rx_wp, r_rx_rp;
    logic [RX_DEPTH_LOG:0]   r_rx_cnt;
    logic                    r_rx_ovf;
    logic [7:0]              r_cpu_din;
    logic                    r_prog_done;

    logic                  w_io, w_sel_data, w_sel_stat;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic                  w_ovf_set, w_stat_rd, w_ram_we;
    logic [7:0]            w_cpu_din_d;
    logic                  w_unused_addr;

    assign w_unused_addr = ^bus.cpu_a[31:18];

    assign w_io       = (bus.cpu_a[17:16] == 2'b11);
    assign w_sel_data = w_io && (bus.cpu_a[15:0] == 16'h0000);
    assign w_sel_stat = w_io && (bus.cpu_a[15:0] == 16'h0004);
    assign w_idx      = bus.cpu_a[ADDR_WIDTH-1:0];

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == TX_CNT_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == RX_CNT_FULL);

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign w_tx_pop  = rdy_in && !w_tx_empty && bus.tx_ready;
    assign w_tx_push = rdy_in && w_sel_data && bus.cpu_wr && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = rdy_in && w_sel_data && !bus.cpu_wr && !w_rx_empty;
    assign w_rx_push = rdy_in && bus.rx_valid && (!w_rx_full || w_rx_pop);
    assign w_ovf_set = rdy_in && bus.rx_valid && w_rx_full && !w_rx_pop;
    assign w_stat_rd = rdy_in && w_sel_stat && !bus.cpu_wr;
    assign w_ram_we  = rdy_in && !w_io && bus.cpu_wr;

    assign bus.cpu_din        = r_cpu_din;
    assign bus.tx_valid       = !w_tx_empty;
    assign bus.tx_data        = r_tx_mem[r_tx_rp];
    assign bus.io_buffer_full = (r_tx_cnt >= TX_CNT_HIGH);
    assign bus.program_done   = r_prog_done;

    always_comb begin
        w_cpu_din_d = r_cpu_din;
        if (rdy_in) begin
            if (bus.cpu_wr) begin
                w_cpu_din_d = 8'h00;
            end else if (!w_io) begin
                w_cpu_din_d = r_ram[w_idx];
            end else if (w_sel_data) begin
                w_cpu_din_d = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
            end else if (w_sel_stat) begin
                w_cpu_din_d = {5'b0, r_rx_ovf, !w_rx_empty, w_tx_full};
            end else begin
                w_cpu_din_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_we) r_ram[w_idx] <= bus.cpu_dout;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.cpu_dout;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cpu_din   <= 8'h00;
            r_prog_done <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_tx_wp     <= '0;
            r_tx_rp     <= '0;
            r_tx_cnt    <= '0;
            r_rx_wp     <= '0;
            r_rx_rp     <= '0;
            r_rx_cnt    <= '0;
        end else begin
            r_cpu_din   <= w_cpu_din_d;
            r_prog_done <= rdy_in && w_sel_stat && bus.cpu_wr;
            // A same-cycle overflow wins over the clear-on-read.
            if (w_ovf_set) r_rx_ovf <= 1'b1;
            else if (w_stat_rd) r_rx_ovf <= 1'b0;

            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PTR_ONE;
            if (w_tx_push && !w_tx_pop) r_tx_cnt <= r_tx_cnt + TX_CNT_ONE;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - TX_CNT_ONE;

            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PTR_ONE;
            if (w_rx_push && !w_rx_pop) r_rx_cnt <= r_rx_cnt + RX_CNT_ONE;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
        end
    end
endmodule
